// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit: bus width, default
// timeout and the FSM state encoding.
package mem_access_unit_pkg;

  localparam int BUS_MSB     = 31;
  localparam int MAU_TIMEOUT = 255;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_REQ  = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_e;

  // Last counter value before a REQ gives up waiting for an ack.
  function automatic logic [7:0] timeout_last(input int timeout);
    return 8'(timeout - 1);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: turns EX/MEM load/store controls into one req/ack
// bus transaction per instruction and stalls the pipeline until it completes.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int BUS_W   = BUS_MSB + 1,
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_WrEnMem,
  input  logic             i_RdEnMem,
  input  logic             i_MemAddrSel,
  input  logic [BUS_W-1:0] i_AluOut,
  input  logic [BUS_W-1:0] i_Imm22,
  input  logic [BUS_W-1:0] i_AluOp2,
  output logic             o_Stall,
  output logic [BUS_W-1:0] o_LoadData,
  output logic             o_LoadValid,
  output logic             o_BusReq,
  output logic             o_BusWe,
  output logic [BUS_W-1:0] o_BusAddr,
  output logic [BUS_W-1:0] o_BusWData,
  input  logic             i_BusAck,
  input  logic [BUS_W-1:0] i_BusRData,
  input  logic             i_BusErr,
  output logic             o_BusFault
);

  localparam logic [7:0] TO_LAST = timeout_last(TIMEOUT);

  mau_state_e       r_State, w_State;
  logic [7:0]       r_Count, w_Count;
  logic             w_Acc;
  logic             w_BusReq, w_BusWe, w_LoadValid, w_Fault;
  logic [BUS_W-1:0] w_BusAddr, w_BusWData, w_LoadData;

  assign w_Acc   = i_WrEnMem | i_RdEnMem;
  // Combinational so the issuing instruction is held from its very first cycle.
  assign o_Stall = ((r_State == MAU_IDLE) && w_Acc) || (r_State == MAU_REQ);

  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!i_Rst) r_State <= MAU_IDLE;
    else        r_State <= w_State;
  end

  always_comb begin
    // NOTE: every output gets a hold default first, so no path can infer a latch.
    w_State     = r_State;
    w_Count     = r_Count;
    w_BusReq    = o_BusReq;
    w_BusWe     = o_BusWe;
    w_BusAddr   = o_BusAddr;
    w_BusWData  = o_BusWData;
    w_LoadData  = o_LoadData;
    w_LoadValid = 1'b0;
    w_Fault     = o_BusFault;

    unique case (r_State)
      MAU_IDLE: begin
        if (w_Acc) begin
          w_State    = MAU_REQ;
          w_BusReq   = 1'b1;
          w_BusWe    = i_WrEnMem;
          w_BusAddr  = i_MemAddrSel ? i_Imm22 : i_AluOut;
          w_BusWData = i_AluOp2;
          w_Count    = 8'd0;
        end
      end
      MAU_REQ: begin
        if (i_BusAck) begin
          w_State     = MAU_DONE;
          w_BusReq    = 1'b0;
          w_LoadValid = ~o_BusWe;
          if (!o_BusWe) w_LoadData = i_BusErr ? '0 : i_BusRData;
          if (i_BusErr) w_Fault = 1'b1;
        end else if (r_Count == TO_LAST) begin
          w_State     = MAU_DONE;
          w_BusReq    = 1'b0;
          w_Fault     = 1'b1;
          w_LoadValid = ~o_BusWe;
          if (!o_BusWe) w_LoadData = '0;
        end else begin
          w_Count = r_Count + 8'd1;
        end
      end
      MAU_DONE: w_State = MAU_IDLE;
      default:  w_State = MAU_IDLE;
    endcase
  end

  // o_LoadValid is registered on entry to DONE, so it is high for exactly that cycle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_Count     <= 8'd0;
      o_BusReq    <= 1'b0;
      o_BusWe     <= 1'b0;
      o_BusAddr   <= '0;
      o_BusWData  <= '0;
      o_LoadData  <= '0;
      o_LoadValid <= 1'b0;
      o_BusFault  <= 1'b0;
    end else begin
      r_Count     <= w_Count;
      o_BusReq    <= w_BusReq;
      o_BusWe     <= w_BusWe;
      o_BusAddr   <= w_BusAddr;
      o_BusWData  <= w_BusWData;
      o_LoadData  <= w_LoadData;
      o_LoadValid <= w_LoadValid;
      o_BusFault  <= w_Fault;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a scripted bus responder per access and
// hand-computed expectations for latency, bus fields, load data and faults.
module tb_mem_access_unit;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_WrEnMem = 1'b0, i_RdEnMem = 1'b0, i_MemAddrSel = 1'b0;
  logic [31:0] i_AluOut = '0, i_Imm22 = '0, i_AluOp2 = '0;
  logic        o_Stall, o_LoadValid, o_BusReq, o_BusWe, o_BusFault;
  logic [31:0] o_LoadData, o_BusAddr, o_BusWData;
  logic        i_BusAck = 1'b0, i_BusErr = 1'b0;
  logic [31:0] i_BusRData = '0;

  int passed = 0;
  int total  = 0;

  // Results of the last run_access call.
  int          ra_stalls, ra_reqs;
  logic        ra_done, ra_valid_done, ra_valid_early, ra_stable, ra_we;
  logic [31:0] ra_addr, ra_wdata;

  mem_access_unit #(.BUS_W(32), .TIMEOUT(4)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_WrEnMem(i_WrEnMem), .i_RdEnMem(i_RdEnMem), .i_MemAddrSel(i_MemAddrSel),
    .i_AluOut(i_AluOut), .i_Imm22(i_Imm22), .i_AluOp2(i_AluOp2),
    .o_Stall(o_Stall), .o_LoadData(o_LoadData), .o_LoadValid(o_LoadValid),
    .o_BusReq(o_BusReq), .o_BusWe(o_BusWe), .o_BusAddr(o_BusAddr),
    .o_BusWData(o_BusWData), .i_BusAck(i_BusAck), .i_BusRData(i_BusRData),
    .i_BusErr(i_BusErr), .o_BusFault(o_BusFault)
  );

  always #5 i_Clk = ~i_Clk;

  // Presents one instruction and answers its bus request in REQ cycle ack_at
  // (0 = never). Returns during the DONE cycle with the next instruction a nop.
  task automatic run_access(input logic wr, input logic rd, input logic sel,
                            input logic [31:0] alu, input logic [31:0] imm,
                            input logic [31:0] op2, input int ack_at,
                            input logic err, input logic [31:0] rdata);
    ra_stalls = 0; ra_reqs = 0; ra_done = 1'b0; ra_valid_done = 1'b0;
    ra_valid_early = 1'b0; ra_stable = 1'b1; ra_we = 1'b0; ra_addr = '0; ra_wdata = '0;
    @(negedge i_Clk);
    i_WrEnMem = wr; i_RdEnMem = rd; i_MemAddrSel = sel;
    i_AluOut = alu; i_Imm22 = imm; i_AluOp2 = op2;
    i_BusAck = 1'b0; i_BusErr = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) begin
        @(negedge i_Clk);
        i_BusAck = 1'b0; i_BusErr = 1'b0;
      end
      #1;
      if (!o_Stall) begin
        ra_done = 1'b1;
        ra_valid_done = o_LoadValid;
        break;
      end
      ra_stalls++;
      if (o_LoadValid) ra_valid_early = 1'b1;
      if (o_BusReq) begin
        ra_reqs++;
        if (ra_reqs == 1) begin
          ra_addr = o_BusAddr; ra_we = o_BusWe; ra_wdata = o_BusWData;
        end else if (o_BusAddr !== ra_addr || o_BusWe !== ra_we || o_BusWData !== ra_wdata) begin
          ra_stable = 1'b0;
        end
        if (ra_reqs == ack_at) begin
          i_BusAck = 1'b1; i_BusErr = err; i_BusRData = rdata;
        end
      end
    end
    i_WrEnMem = 1'b0; i_RdEnMem = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1'b1;
  endtask

  task automatic test_reset();
    i_Rst = 1'b0; i_RdEnMem = 1'b1; i_AluOut = 32'h55;
    @(negedge i_Clk);
    @(negedge i_Clk);
    #1;
    total++; if (o_BusReq !== 1'b0) $display("FAIL reset_req: got %b want 0", o_BusReq); else passed++;
    total++; if (o_Stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", o_Stall); else passed++;
    total++;
    if ({o_BusWe, o_BusAddr, o_BusWData, o_LoadData, o_LoadValid, o_BusFault} !== '0)
      $display("FAIL reset_regs: we=%b addr=%h wd=%h ld=%h lv=%b flt=%b want all 0",
               o_BusWe, o_BusAddr, o_BusWData, o_LoadData, o_LoadValid, o_BusFault);
    else passed++;
    i_RdEnMem = 1'b0; i_Rst = 1'b1;
  endtask

  task automatic test_load();
    run_access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 3, 1'b0, 32'hDEADBEEF);
    total++; if (ra_done !== 1'b1) $display("FAIL load_done: timed out, want release"); else passed++;
    total++; if (ra_addr !== 32'h100) $display("FAIL load_addr: got %h want 00000100", ra_addr); else passed++;
    total++; if (ra_we !== 1'b0) $display("FAIL load_we: got %b want 0", ra_we); else passed++;
    total++; if (ra_stalls != 4) $display("FAIL load_stall: got %0d want 4", ra_stalls); else passed++;
    total++; if (ra_reqs != 3) $display("FAIL load_req_cycles: got %0d want 3", ra_reqs); else passed++;
    total++; if (ra_stable !== 1'b1) $display("FAIL load_stable: bus fields changed during REQ"); else passed++;
    total++; if (o_LoadData !== 32'hDEADBEEF) $display("FAIL load_data: got %h want deadbeef", o_LoadData); else passed++;
    total++;
    if (ra_valid_done !== 1'b1 || ra_valid_early !== 1'b0)
      $display("FAIL load_valid: done=%b early=%b want 1/0", ra_valid_done, ra_valid_early);
    else passed++;
    @(negedge i_Clk); #1;
    total++; if (o_LoadValid !== 1'b0) $display("FAIL load_valid_pulse: got %b want 0", o_LoadValid); else passed++;
    total++; if (o_Stall !== 1'b0) $display("FAIL load_idle_stall: got %b want 0", o_Stall); else passed++;
  endtask

  task automatic test_store();
    run_access(1'b1, 1'b0, 1'b1, 32'h777, 32'h3F0, 32'h1234, 1, 1'b0, 32'hFFFF0000);
    total++; if (ra_we !== 1'b1) $display("FAIL store_we: got %b want 1", ra_we); else passed++;
    total++; if (ra_addr !== 32'h3F0) $display("FAIL store_addr: got %h want 000003f0", ra_addr); else passed++;
    total++; if (ra_wdata !== 32'h1234) $display("FAIL store_wdata: got %h want 00001234", ra_wdata); else passed++;
    total++; if (ra_stalls != 2 || ra_done !== 1'b1) $display("FAIL store_stall: got %0d want 2", ra_stalls); else passed++;
    total++; if (ra_valid_done !== 1'b0) $display("FAIL store_novalid: got %b want 0", ra_valid_done); else passed++;
    total++; if (o_LoadData !== 32'hDEADBEEF) $display("FAIL store_hold_ld: got %h want deadbeef", o_LoadData); else passed++;
    total++; if (o_BusFault !== 1'b0) $display("FAIL store_fault: got %b want 0", o_BusFault); else passed++;
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'hAB, 1, 1'b0, 32'h0BAD0BAD);
    total++;
    if (ra_we !== 1'b1 || ra_reqs != 1 || ra_valid_done !== 1'b0)
      $display("FAIL wr_rd_both: we=%b reqs=%0d valid=%b want 1/1/0", ra_we, ra_reqs, ra_valid_done);
    else passed++;
    total++; if (o_LoadData !== 32'hDEADBEEF) $display("FAIL wr_rd_noread: got %h want deadbeef", o_LoadData); else passed++;
    @(negedge i_Clk); #1;
    total++;
    if (o_BusReq !== 1'b0 || o_Stall !== 1'b0)
      $display("FAIL wr_rd_reissue: req=%b stall=%b want 0/0", o_BusReq, o_Stall);
    else passed++;
    run_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1, 1'b0, 32'h11111111);
    total++;
    if (ra_addr !== 32'h10 || ra_stalls < 2 || ra_reqs != 1 || o_LoadData !== 32'h11111111)
      $display("FAIL b2b_first: addr=%h stalls=%0d reqs=%0d ld=%h want 10/>=2/1/11111111",
               ra_addr, ra_stalls, ra_reqs, o_LoadData);
    else passed++;
    run_access(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h0, 2, 1'b0, 32'h22222222);
    total++;
    if (ra_addr !== 32'h20 || ra_stalls != 3 || ra_reqs != 2 || o_LoadData !== 32'h22222222 || ra_valid_done !== 1'b1)
      $display("FAIL b2b_second: addr=%h stalls=%0d reqs=%0d ld=%h want 20/3/2/22222222",
               ra_addr, ra_stalls, ra_reqs, o_LoadData);
    else passed++;
  endtask

  task automatic test_timeout_err();
    run_access(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b0, 32'h0);
    total++; if (ra_done !== 1'b1) $display("FAIL to_release: pipeline never released"); else passed++;
    total++; if (ra_reqs != 4 || ra_stalls != 5) $display("FAIL to_cycles: reqs=%0d stalls=%0d want 4/5", ra_reqs, ra_stalls); else passed++;
    total++; if (o_BusFault !== 1'b1) $display("FAIL to_fault: got %b want 1", o_BusFault); else passed++;
    total++; if (o_LoadData !== 32'h0) $display("FAIL to_ld: got %h want 0", o_LoadData); else passed++;
    total++; if (o_BusReq !== 1'b0) $display("FAIL to_req: got %b want 0", o_BusReq); else passed++;
    do_reset();
    run_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1, 1'b0, 32'hCAFEF00D);
    total++;
    if (o_BusFault !== 1'b0 || o_LoadData !== 32'hCAFEF00D)
      $display("FAIL err_pre: flt=%b ld=%h want 0/cafef00d", o_BusFault, o_LoadData);
    else passed++;
    run_access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 1, 1'b1, 32'h5555);
    total++; if (o_BusFault !== 1'b1) $display("FAIL err_fault: got %b want 1", o_BusFault); else passed++;
    total++; if (o_LoadData !== 32'h0) $display("FAIL err_ld: got %h want 0", o_LoadData); else passed++;
    run_access(1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h9, 1, 1'b0, 32'h0);
    total++; if (o_BusFault !== 1'b1) $display("FAIL fault_sticky: got %b want 1", o_BusFault); else passed++;
  endtask

  task automatic test_reset_in_req();
    do_reset();
    @(negedge i_Clk);
    i_RdEnMem = 1'b1; i_AluOut = 32'h400;
    @(negedge i_Clk); #1;
    total++; if (o_BusReq !== 1'b1) $display("FAIL rreq_issue: got %b want 1", o_BusReq); else passed++;
    i_Rst = 1'b0;
    @(negedge i_Clk); #1;
    total++; if (o_BusReq !== 1'b0) $display("FAIL rreq_drop: got %b want 0", o_BusReq); else passed++;
    i_Rst = 1'b1; i_RdEnMem = 1'b0; i_BusAck = 1'b1; i_BusRData = 32'h9999;
    @(negedge i_Clk); #1;
    i_BusAck = 1'b0;
    total++;
    if (o_BusReq !== 1'b0 || o_Stall !== 1'b0 || o_LoadValid !== 1'b0 || o_LoadData !== 32'h0)
      $display("FAIL rreq_late_ack: req=%b stall=%b lv=%b ld=%h want 0/0/0/0",
               o_BusReq, o_Stall, o_LoadValid, o_LoadData);
    else passed++;
    run_access(1'b0, 1'b1, 1'b0, 32'h404, 32'h0, 32'h0, 1, 1'b0, 32'h600D);
    total++;
    if (ra_stalls != 2 || o_LoadData !== 32'h600D || ra_addr !== 32'h404)
      $display("FAIL rreq_recover: stalls=%0d ld=%h addr=%h want 2/600d/404", ra_stalls, o_LoadData, ra_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout_err();
    test_reset_in_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
